// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and defaults.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } state_e;

  localparam int unsigned DEFAULT_STABLE_CNT = 50000;
  localparam int unsigned SYNC_DEPTH         = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff
  import debounce_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [SYNC_DEPTH-1:0] ff_q;
  logic [SYNC_DEPTH-1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[SYNC_DEPTH-2:0], din};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign dout = ff_q[SYNC_DEPTH-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw input into a clean level plus rise/fall/en strobes for a latch.
// Define INPUT_DEBOUNCE_SYNC_EN to place a 2-FF synchronizer in front of the FSM.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic en_pulse,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CNT - 1);

  logic s;

`ifdef INPUT_DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk  (clk),
    .clr  (clr),
    .din  (din),
    .dout (s)
  );
`else
  assign s = din;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             en_pulse_q, en_pulse_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        cnt_d = '0;
        if (s) state_d = WAIT_HI;
      end
      IDLE_HI: begin
        cnt_d = '0;
        if (!s) state_d = WAIT_LO;
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
    // busy mirrors the next state so it rises on WAIT entry and drops on exit
    busy_d     = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    en_pulse_d = rise_d | fall_d;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE_LO;
      cnt_q      <= '0;
      dout_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      en_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      en_pulse_q <= en_pulse_d;
      busy_q     <= busy_d;
    end
  end

  assign dout     = dout_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign en_pulse = en_pulse_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with STABLE_CNT=4 against a run-length reference model.
module tb_input_debouncer;

  localparam int SC = 4;
`ifdef INPUT_DEBOUNCE_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 0;
`endif
  localparam int LAT = SC + DEPTH;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic din = 1'b0;
  logic dout, en_pulse, rise, fall, busy;

  input_debouncer #(.STABLE_CNT(SC), .CNT_W(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .din      (din),
    .dout     (dout),
    .en_pulse (en_pulse),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: dout flips once s has differed from it for SC+1 consecutive edges.
  logic m_dout, m_rise, m_fall, m_busy;
  int   run;
  logic hist[$];

  int edge_num, first_pulse, pulse_count, busy_count;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    run = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(1'b0);
  endtask

  task automatic model_edge();
    logic s;
`ifdef INPUT_DEBOUNCE_SYNC_EN
    s = hist[DEPTH-1];
    hist.push_front(din);
    void'(hist.pop_back());
`else
    s = din;
`endif
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_dout) begin
      run++;
      if (run == SC + 1) begin
        m_dout = s;
        m_rise = s;
        m_fall = !s;
        run = 0;
      end
    end else begin
      run = 0;
    end
    m_busy = (run > 0);
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_dout"}, dout, m_dout);
    check({pfx, "_en_pulse"}, en_pulse, m_rise | m_fall);
    check({pfx, "_rise"}, rise, m_rise);
    check({pfx, "_fall"}, fall, m_fall);
    check({pfx, "_busy"}, busy, m_busy);
  endtask

  task automatic begin_scn();
    edge_num = 0; first_pulse = -1; pulse_count = 0; busy_count = 0;
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    din = v;
    @(posedge clk);
    if (clr) model_edge();
    #1;
    check_outputs("cyc");
    if (en_pulse === 1'b1) begin
      if (first_pulse < 0) first_pulse = edge_num;
      pulse_count++;
    end
    if (busy === 1'b1) busy_count++;
    edge_num++;
  endtask

  initial begin
    int  len;
    logic v;
    bit  found;

    // 1: reset with din high, then release and hold high
    din = 1'b1;
    #1 clr = 1'b0;
    model_reset();
    #1 check_outputs("rst");
    repeat (2) step(1'b1);
    clr = 1'b1;
    begin_scn();
    repeat (10) step(1'b1);
    check_int("s1_latency", first_pulse, LAT);
    check_int("s1_pulses", pulse_count, 1);
    $display("scn1 reset-release: first_pulse=%0d pulses=%0d", first_pulse, pulse_count);

    // 2: clean steps
    repeat (12) step(1'b0);
    begin_scn();
    repeat (10) step(1'b1);
    check_int("s2_rise_latency", first_pulse, LAT);
    check_int("s2_rise_busy", busy_count, SC);
    begin_scn();
    repeat (10) step(1'b0);
    check_int("s2_fall_latency", first_pulse, LAT);
    check_int("s2_fall_busy", busy_count, SC);
    $display("scn2 clean steps done");

    // 3: bounce then hold high
    begin_scn();
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    repeat (10) step(1'b1);
    check_int("s3_latency", first_pulse, 4 + LAT);
    check_int("s3_pulses", pulse_count, 1);
    $display("scn3 bounce: first_pulse=%0d", first_pulse);

    // 4: short glitch from dout=0
    repeat (10) step(1'b0);
    begin_scn();
    repeat (3) step(1'b1);
    repeat (10) step(1'b0);
    check_int("s4_pulses", pulse_count, 0);
    check_int("s4_busy", busy_count, 3);
    $display("scn4 glitch: pulses=%0d busy_cycles=%0d", pulse_count, busy_count);

    // 5: asynchronous reset two edges into WAIT
    begin_scn();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1);
      if (busy === 1'b1) found = 1'b1;
    end
    check("s5_wait_entered", found, 1'b1);
    repeat (2) step(1'b1);
    clr = 1'b0;
    model_reset();
    #1 check_outputs("s5_async");
    repeat (2) step(1'b1);
    clr = 1'b1;
    begin_scn();
    repeat (10) step(1'b1);
    check_int("s5_latency", first_pulse, LAT);
    check_int("s5_pulses", pulse_count, 1);
    $display("scn5 mid-wait reset: first_pulse=%0d", first_pulse);

    // random runs against the model
    for (int r = 0; r < 120; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, SC + 4);
      repeat (len) step(v);
    end
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
